// File: rtl/fanout_bcast_pkg.sv
// Shared types and helpers for the broadcast distributor.
package fanout_bcast_pkg;

  localparam int unsigned MAX_LOADS = 16;
  localparam int unsigned CNT_W     = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Mask with the low n bits set, used as the "every load has accepted" pattern.
  function automatic logic [MAX_LOADS-1:0] all_ones(input int unsigned n);
    logic [MAX_LOADS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LOADS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcast_skid_fifo.sv
// Two-entry registered FIFO; the caller guarantees no push when full and no pop when empty.
module bcast_skid_fifo
  import fanout_bcast_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = mem_q[head_q];

endmodule

// File: rtl/fanout_bcast_dist.sv
// Broadcasts each buffered item to NUM_LOADS sinks; an item retires once every load has taken it.
module fanout_bcast_dist
  import fanout_bcast_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_LOADS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM_LOADS-1:0] out_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 busy,
  output logic [15:0]          bcast_cnt
);

  localparam logic [MAX_LOADS-1:0] ALL_MASK  = all_ones(NUM_LOADS);
  localparam logic [NUM_LOADS-1:0] DONE_FULL = ALL_MASK[NUM_LOADS-1:0];

  logic [1:0]           count;
  logic                 head_valid;
  logic [WIDTH-1:0]     head_data;
  logic                 push;
  logic                 retire;
  logic [NUM_LOADS-1:0] fire;

  logic [NUM_LOADS-1:0] done_q, done_d;
  cnt_t                 cnt_q, cnt_d;
  logic [WIDTH-1:0]     last_q, last_d;

  bcast_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (in_data),
    .pop        (retire),
    .count      (count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  // Ready depends only on the occupancy register, never on out_ready.
  assign in_ready  = ~rst & (count != 2'd2);
  assign push      = in_valid & in_ready;
  assign out_valid = {NUM_LOADS{head_valid & ~rst}} & ~done_q;
  assign fire      = out_valid & out_ready;
  assign retire    = head_valid & ~rst & ((done_q | fire) == DONE_FULL);

  always_comb begin
    done_d = done_q | fire;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (retire) begin
      done_d = '0;
      cnt_d  = cnt_q + cnt_t'(1);
    end
    if (head_valid) begin
      last_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Hold the last delivered payload on the bus while the buffer is empty.
  assign out_data  = head_valid ? head_data : last_q;
  assign busy      = (count != 2'd0);
  assign bcast_cnt = cnt_q;

endmodule
